multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/arm_cpu_pkg.sv | 37 +++
 rtl/multi_cycle_control_if.sv | 10 +
 rtl/opcode_classifier.sv | 28 ++
 rtl/multi_cycle_control.sv | 169 ++++++++++++++++
 tb/tb_multi_cycle_control.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_cpu_pkg.sv
// Shared types and constants for the multi-cycle ARM control unit: FSM states,
// decoded instruction classes, opcode patterns and ALU operation codes.
package arm_cpu_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMemAccess,
    StWriteback,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsNone,
    ClsLdur,
    ClsStur,
    ClsRtype,
    ClsCbz,
    ClsB
  } instr_class_e;

  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  // CBZ and B carry immediate bits in the low opcode positions.
  localparam logic [7:0]  OpCbzPrefix = 8'b10110100;
  localparam logic [5:0]  OpBPrefix   = 6'b000101;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpPassB = 2'b01;
  localparam logic [1:0] AluOpRtype = 2'b10;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Shared-memory handshake between the control unit (master) and the memory (slave).
interface multi_cycle_control_if;
  logic mem_request;
  logic mem_write;
  logic address_select;
  logic mem_ready;

  modport master (output mem_request, output mem_write, output address_select, input mem_ready);
  modport slave  (input mem_request, input mem_write, input address_select, output mem_ready);
endinterface

// File: rtl/opcode_classifier.sv
// Combinational opcode decode into an instruction class plus an illegal-opcode flag.
module opcode_classifier
  import arm_cpu_pkg::*;
(
  input  logic [10:0]  i_opcode,
  output instr_class_e o_class,
  output logic         o_illegal
);

  always_comb begin
    o_class   = ClsNone;
    o_illegal = 1'b0;
    if (i_opcode == OpLdur) begin
      o_class = ClsLdur;
    end else if (i_opcode == OpStur) begin
      o_class = ClsStur;
    end else if (i_opcode inside {OpAdd, OpSub, OpAnd, OpOrr}) begin
      o_class = ClsRtype;
    end else if (i_opcode[10:3] == OpCbzPrefix) begin
      o_class = ClsCbz;
    end else if (i_opcode[10:5] == OpBPrefix) begin
      o_class = ClsB;
    end else begin
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback,
// guards memory waits with a timeout, and counts retired instructions.
module multi_cycle_control
  import arm_cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [10:0]                i_opcode,
  input  logic                       i_zero_alu,
  multi_cycle_control_if.master      mem_if,
  output logic                       o_ir_write,
  output logic                       o_pc_write,
  output logic                       o_pc_source,
  output logic                       o_reg_to_loc,
  output logic                       o_alu_src,
  output logic                       o_mem_to_reg,
  output logic                       o_reg_write,
  output logic [1:0]                 o_alu_op,
  output logic                       o_halted,
  output logic                       o_illegal_opcode,
  output logic                       o_mem_timeout,
  output logic [COUNT_WIDTH-1:0]     o_retired_count
);

  localparam int unsigned WaitWidth = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e                 r_state;
  instr_class_e           r_class;
  logic [WaitWidth-1:0]   r_wait;
  logic                   r_halted;
  logic                   r_illegal;
  logic                   r_timeout;
  logic [COUNT_WIDTH-1:0] r_retired;

  state_e       w_next;
  instr_class_e w_dec_class;
  logic         w_dec_illegal;
  logic         w_mem_req;
  logic         w_mem_done;
  logic         w_stall;
  logic         w_timeout_hit;
  logic         w_retire;

  opcode_classifier u_classifier (
    .i_opcode  (i_opcode),
    .o_class   (w_dec_class),
    .o_illegal (w_dec_illegal)
  );

  // mem_ready only counts while a request is actually outstanding.
  assign w_mem_req     = (r_state == StFetch) || (r_state == StMemAccess);
  assign w_mem_done    = w_mem_req && mem_if.mem_ready;
  assign w_stall       = w_mem_req && !mem_if.mem_ready;
  assign w_timeout_hit = w_stall && (r_wait == WaitWidth'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StFetch:     if (w_mem_done) w_next = StDecode;
      StDecode:    w_next = w_dec_illegal ? StHalt : StExecute;
      StExecute: begin
        case (r_class)
          ClsLdur, ClsStur: w_next = StMemAccess;
          ClsRtype:         w_next = StWriteback;
          default:          w_next = StFetch;
        endcase
      end
      StMemAccess: if (w_mem_done) w_next = (r_class == ClsStur) ? StFetch : StWriteback;
      StWriteback: w_next = StFetch;
      default:     w_next = StHalt;
    endcase
    if (w_timeout_hit) w_next = StHalt;
  end

  assign w_retire = (w_next == StFetch) && (r_state != StFetch);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= StFetch;
      r_class   <= ClsNone;
      r_wait    <= '0;
      r_retired <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (w_stall) begin
        r_wait <= r_wait + WaitWidth'(1);
      end
      if (r_state == StDecode) begin
        r_class <= w_dec_class;
        if (w_dec_illegal) r_illegal <= 1'b1;
      end
      if (w_timeout_hit)     r_timeout <= 1'b1;
      if (w_next == StHalt)  r_halted  <= 1'b1;
      if (w_retire)          r_retired <= r_retired + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    mem_if.mem_request    = 1'b0;
    mem_if.mem_write      = 1'b0;
    mem_if.address_select = 1'b0;
    o_ir_write            = 1'b0;
    o_pc_write            = 1'b0;
    o_pc_source           = 1'b0;
    o_reg_to_loc          = 1'b0;
    o_alu_src             = 1'b0;
    o_mem_to_reg          = 1'b0;
    o_reg_write           = 1'b0;
    o_alu_op              = AluOpAdd;
    unique case (r_state)
      StFetch: begin
        mem_if.mem_request = 1'b1;
        if (mem_if.mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
        end
      end
      StExecute: begin
        case (r_class)
          ClsLdur, ClsStur: o_alu_src = 1'b1;
          ClsRtype:         o_alu_op  = AluOpRtype;
          ClsCbz: begin
            o_reg_to_loc = 1'b1;
            o_alu_op     = AluOpPassB;
            o_pc_write   = i_zero_alu;
            o_pc_source  = 1'b1;
          end
          ClsB: begin
            o_pc_write  = 1'b1;
            o_pc_source = 1'b1;
          end
          default: ;
        endcase
      end
      StMemAccess: begin
        mem_if.mem_request    = 1'b1;
        mem_if.address_select = 1'b1;
        mem_if.mem_write      = (r_class == ClsStur);
        o_reg_to_loc          = (r_class == ClsStur);
      end
      StWriteback: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = (r_class == ClsLdur);
      end
      default: ;
    endcase
    // No architectural write may slip out while reset is being applied.
    if (i_reset) begin
      o_ir_write       = 1'b0;
      o_pc_write       = 1'b0;
      o_reg_write      = 1'b0;
      mem_if.mem_write = 1'b0;
    end
  end

  assign o_halted         = r_halted;
  assign o_illegal_opcode = r_illegal;
  assign o_mem_timeout    = r_timeout;
  assign o_retired_count  = r_retired;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed scenarios plus random
// instruction streams compared every cycle against a behavioural model.
module tb_multi_cycle_control;

  localparam int T  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [10:0]   opcode = '0;
  logic          zero = 1'b0;
  logic          ir_write, pc_write, pc_source, reg_to_loc, alu_src, mem_to_reg, reg_write;
  logic [1:0]    alu_op;
  logic          halted, illegal, tmo;
  logic [CW-1:0] retired;

  multi_cycle_control_if bus ();

  multi_cycle_control #(.MEM_TIMEOUT(T), .COUNT_WIDTH(CW)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_opcode         (opcode),
    .i_zero_alu       (zero),
    .mem_if           (bus),
    .o_ir_write       (ir_write),
    .o_pc_write       (pc_write),
    .o_pc_source      (pc_source),
    .o_reg_to_loc     (reg_to_loc),
    .o_alu_src        (alu_src),
    .o_mem_to_reg     (mem_to_reg),
    .o_reg_write      (reg_write),
    .o_alu_op         (alu_op),
    .o_halted         (halted),
    .o_illegal_opcode (illegal),
    .o_mem_timeout    (tmo),
    .o_retired_count  (retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction class: 0 illegal, 1 LDUR, 2 STUR, 3 R-type, 4 CBZ, 5 B.
  function automatic int classify(input logic [10:0] op);
    if (op == 11'b11111000010) return 1;
    if (op == 11'b11111000000) return 2;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return 3;
    if (op[10:3] == 8'b10110100) return 4;
    if (op[10:5] == 6'b000101) return 5;
    return 0;
  endfunction

  // Model: phase 0 fetch, 1 decode, 2 execute, 3 memory, 4 writeback, 5 halted.
  bit model_valid = 0;
  int m_phase, m_cls, m_waits, m_retired;
  bit m_halted, m_illegal, m_tmo;

  task automatic model_step();
    int prev;
    if (rst) begin
      model_valid = 1;
      m_phase = 0; m_cls = 0; m_waits = 0; m_retired = 0;
      m_halted = 0; m_illegal = 0; m_tmo = 0;
      return;
    end
    if (!model_valid) return;
    prev = m_phase;
    if ((m_phase == 0 || m_phase == 3) && !bus.mem_ready) begin
      m_waits++;
      if (m_waits == T) begin
        m_tmo = 1; m_halted = 1; m_phase = 5;
      end
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: begin
          m_cls = classify(opcode);
          if (m_cls == 0) begin
            m_illegal = 1; m_halted = 1; m_phase = 5;
          end else m_phase = 2;
        end
        2: if (m_cls == 1 || m_cls == 2) m_phase = 3;
           else if (m_cls == 3) m_phase = 4;
           else begin m_phase = 0; m_retired = (m_retired + 1) % (1 << CW); end
        3: if (m_cls == 2) begin m_phase = 0; m_retired = (m_retired + 1) % (1 << CW); end
           else m_phase = 4;
        4: begin m_phase = 0; m_retired = (m_retired + 1) % (1 << CW); end
        default: ;
      endcase
    end
    if (m_phase != prev) m_waits = 0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  function automatic logic [18:0] expected();
    bit ex = (m_phase == 2);
    bit fetch_go = (m_phase == 0) && bus.mem_ready;
    logic [1:0] aop = 2'b00;
    if (ex && m_cls == 3) aop = 2'b10;
    if (ex && m_cls == 4) aop = 2'b01;
    return {(m_phase == 0 || m_phase == 3), (m_phase == 3 && m_cls == 2), (m_phase == 3),
            fetch_go,
            fetch_go || (ex && (m_cls == 5 || (m_cls == 4 && zero))),
            (ex && (m_cls == 4 || m_cls == 5)),
            ((m_phase == 3 && m_cls == 2) || (ex && m_cls == 4)),
            (ex && (m_cls == 1 || m_cls == 2)),
            (m_phase == 4 && m_cls == 1), (m_phase == 4), aop,
            m_halted, m_illegal, m_tmo, CW'(m_retired)};
  endfunction

  function automatic logic [11:0] ctrl_vec();
    return {bus.mem_request, bus.mem_write, bus.address_select, ir_write, pc_write, pc_source,
            reg_to_loc, alu_src, mem_to_reg, reg_write, alu_op};
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst) check("strobes during reset", {ir_write, pc_write, reg_write, bus.mem_write}, 4'b0);
    else if (model_valid) check("cycle outputs", {ctrl_vec(), halted, illegal, tmo, retired},
                                expected());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] rand_op();
    case ($urandom_range(0, 8))
      0: return 11'b11111000010;
      1: return 11'b11111000000;
      2: return 11'b10001011000;
      3: return 11'b11001011000;
      4: return 11'b10001010000;
      5: return 11'b10101010000;
      6: return {8'b10110100, 3'($urandom)};
      7: return {6'b000101, 5'($urandom)};
      default: return 11'($urandom);
    endcase
  endfunction

  logic [3:0] p_rw, p_ir;
  logic [7:0] p_req, p_as, p_rw8, rdy_tab;
  logic [1:0] wb;
  logic [2:0] p_pcw, p_pcs;

  initial begin
    bus.mem_ready = 1'b1;
    opcode = 11'b10001011000;
    cyc(); cyc();
    rst = 0;

    // ADD with memory always ready.
    p_rw = '0; p_ir = '0;
    for (int c = 0; c < 4; c++) begin
      #2; p_rw = {p_rw[2:0], reg_write}; p_ir = {p_ir[2:0], ir_write};
      cyc();
    end
    check("add reg_write cycles", p_rw, 4'b0001);
    check("add ir_write cycles", p_ir, 4'b1000);
    check("add retired", retired, 1);
    check("add back in fetch", {bus.mem_request, bus.address_select}, 2'b10);

    // LDUR with three wait cycles in the memory phase.
    opcode = 11'b11111000010;
    rdy_tab = 8'b11100011;
    p_req = '0; p_as = '0; p_rw8 = '0; wb = '0;
    for (int c = 0; c < 8; c++) begin
      bus.mem_ready = rdy_tab[7-c];
      #2;
      p_req = {p_req[6:0], bus.mem_request};
      p_as  = {p_as[6:0], bus.address_select};
      p_rw8 = {p_rw8[6:0], reg_write};
      if (c == 7) wb = {mem_to_reg, reg_write};
      cyc();
    end
    check("ldur mem_request", p_req, 8'b10011110);
    check("ldur address_select", p_as, 8'b00011110);
    check("ldur reg_write", p_rw8, 8'b00000001);
    check("ldur writeback", wb, 2'b11);
    check("ldur retired", retired, 2);

    // CBZ not taken, then taken.
    opcode = 11'b10110100101;
    bus.mem_ready = 1'b1;
    for (int z = 0; z < 2; z++) begin
      zero = z[0]; p_pcw = '0; p_pcs = '0;
      for (int c = 0; c < 3; c++) begin
        #2; p_pcw = {p_pcw[1:0], pc_write}; p_pcs = {p_pcs[1:0], pc_source};
        cyc();
      end
      check($sformatf("cbz pc_write zero=%0d", z), p_pcw, (z == 1) ? 3'b101 : 3'b100);
      check($sformatf("cbz pc_source zero=%0d", z), p_pcs, 3'b001);
      check($sformatf("cbz retired zero=%0d", z), retired, 3 + z);
    end

    // Illegal opcode halts and holds outputs quiet.
    opcode = 11'b11111111111;
    cyc(); cyc();
    check("illegal flags", {halted, illegal, tmo}, 3'b110);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = 1'($urandom); zero = 1'($urandom);
      #2; check("halt controls quiet", ctrl_vec(), 12'b0);
      cyc();
    end
    bus.mem_ready = 1'b0;
    rst = 1; cyc(); rst = 0;
    check("reset leaves halt", {bus.mem_request, halted, illegal, retired}, {3'b100, 4'd0});

    // Fetch timeout after T unanswered cycles.
    for (int c = 0; c < T; c++) begin
      #2; if (c == T - 1) check("not halted before timeout", halted, 0);
      cyc();
    end
    check("timeout flags", {halted, illegal, tmo, bus.mem_request}, 4'b1010);

    // Retired counter wraps from all-ones to zero.
    rst = 1; cyc(); rst = 0;
    bus.mem_ready = 1'b1;
    opcode = 11'b00010100000;
    repeat (15 * 3) cyc();
    check("retired all ones", retired, 4'hF);
    repeat (3) cyc();
    check("retired wraps", retired, 0);

    // Random instruction streams with stalls, timeouts and resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0) || (m_halted && $urandom_range(0, 3) == 0);
      bus.mem_ready = ($urandom_range(0, 9) < 7);
      zero = 1'($urandom_range(0, 1));
      opcode = rand_op();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
